// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch-on-load and
// memory-hold hazards, plus a registered stall-reason FSM and saturating counters.
module hazard_stall_unit #(
   parameter int         CNT_W    = 16,
   parameter logic [4:0] ZERO_REG = 5'd0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       IF_ID_Rs,
   input  logic [4:0]       IF_ID_Rt,
   input  logic             IF_ID_useRt,
   input  logic             IF_ID_branch,
   input  logic             ID_EX_memRead,
   input  logic [4:0]       ID_EX_Rt,
   input  logic             EX_MEM_memRead,
   input  logic [4:0]       EX_MEM_Rd,
   input  logic             branch_taken,
   input  logic             mem_busy,
   output logic             PC_write,
   output logic             IF_ID_write,
   output logic             ID_EX_write,
   output logic             ID_EX_bubble,
   output logic             IF_ID_flush,
   output logic [1:0]       stall_reason,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      LU_STALL = 2'b01,
      BR_STALL = 2'b10,
      MEM_HOLD = 2'b11
   } state_t;

   state_t state, next_state;
   logic   hz_lu, hz_br;

   function automatic logic match(input logic [4:0] r, input logic [4:0] x);
      return (r != ZERO_REG) && (r == x);
   endfunction

   // The qualifying enable sits on the left of && so a don't-care register
   // index cannot leak into the hazard terms.
   assign hz_lu = ID_EX_memRead &&
                  (match(ID_EX_Rt, IF_ID_Rs) || (IF_ID_useRt && match(ID_EX_Rt, IF_ID_Rt)));
   assign hz_br = IF_ID_branch && EX_MEM_memRead &&
                  (match(EX_MEM_Rd, IF_ID_Rs) || (IF_ID_useRt && match(EX_MEM_Rd, IF_ID_Rt)));

   always_comb begin
      PC_write     = 1'b1;
      IF_ID_write  = 1'b1;
      ID_EX_write  = 1'b1;
      ID_EX_bubble = 1'b0;
      IF_ID_flush  = 1'b0;
      next_state   = RUN;
      if (mem_busy) begin
         PC_write    = 1'b0;
         IF_ID_write = 1'b0;
         ID_EX_write = 1'b0;
         next_state  = MEM_HOLD;
      end else if (hz_lu || hz_br) begin
         // Stalled branch compares stale data, so its taken flag is dropped.
         PC_write     = 1'b0;
         IF_ID_write  = 1'b0;
         ID_EX_bubble = 1'b1;
         next_state   = hz_lu ? LU_STALL : BR_STALL;
      end else begin
         IF_ID_flush = branch_taken;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RUN;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         state <= next_state;
         if (next_state != RUN && stall_cycles != {CNT_W{1'b1}})
            stall_cycles <= stall_cycles + 1'b1;
         if (IF_ID_flush && flush_count != {CNT_W{1'b1}})
            flush_count <= flush_count + 1'b1;
      end
   end

   assign stall_reason = state;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit; counters built 4 bits wide to reach saturation.
module tb_hazard_stall_unit;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [4:0]       IF_ID_Rs, IF_ID_Rt, ID_EX_Rt, EX_MEM_Rd;
   logic             IF_ID_useRt, IF_ID_branch, ID_EX_memRead, EX_MEM_memRead;
   logic             branch_taken, mem_busy;
   logic             PC_write, IF_ID_write, ID_EX_write, ID_EX_bubble, IF_ID_flush;
   logic [1:0]       stall_reason;
   logic [CNT_W-1:0] stall_cycles, flush_count;

   int checks = 0;
   int errors = 0;

   hazard_stall_unit #(.CNT_W(CNT_W), .ZERO_REG(5'd0)) dut (
      .clk(clk), .rst_n(rst_n),
      .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_useRt(IF_ID_useRt),
      .IF_ID_branch(IF_ID_branch), .ID_EX_memRead(ID_EX_memRead), .ID_EX_Rt(ID_EX_Rt),
      .EX_MEM_memRead(EX_MEM_memRead), .EX_MEM_Rd(EX_MEM_Rd),
      .branch_taken(branch_taken), .mem_busy(mem_busy),
      .PC_write(PC_write), .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write),
      .ID_EX_bubble(ID_EX_bubble), .IF_ID_flush(IF_ID_flush),
      .stall_reason(stall_reason), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {PC_write, IF_ID_write, ID_EX_write, ID_EX_bubble, IF_ID_flush}
   function automatic logic [31:0] ctl();
      return {27'd0, PC_write, IF_ID_write, ID_EX_write, ID_EX_bubble, IF_ID_flush};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      IF_ID_Rs = 5'd1; IF_ID_Rt = 5'd2; IF_ID_useRt = 1'b0; IF_ID_branch = 1'b0;
      ID_EX_memRead = 1'b0; ID_EX_Rt = 5'd3; EX_MEM_memRead = 1'b0; EX_MEM_Rd = 5'd4;
      branch_taken = 1'b0; mem_busy = 1'b0;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      #2;
      chk("reset_reason", stall_reason, 2'b00);
      chk("reset_stall_cycles", stall_cycles, 0);
      chk("reset_flush_count", flush_count, 0);
      chk("reset_comb_run", ctl(), 5'b11100);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // load-use on rs
      ID_EX_memRead = 1'b1; ID_EX_Rt = 5'd8; IF_ID_Rs = 5'd8;
      #1 chk("lu_ctl", ctl(), 5'b00110);
      tick();
      chk("lu_reason", stall_reason, 2'b01);
      chk("lu_cycles", stall_cycles, 1);

      // zero register never hazards
      ID_EX_Rt = 5'd0; IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0; IF_ID_useRt = 1'b1;
      #1 chk("zero_ctl", ctl(), 5'b11100);
      tick();
      chk("zero_reason", stall_reason, 2'b00);
      chk("zero_cycles", stall_cycles, 1);

      // rt match only counts when rt is read
      IF_ID_Rs = 5'd1; ID_EX_Rt = 5'd5; IF_ID_Rt = 5'd5; IF_ID_useRt = 1'b0;
      #1 chk("rt_unused_ctl", ctl(), 5'b11100);
      IF_ID_useRt = 1'b1;
      #1 chk("rt_used_ctl", ctl(), 5'b00110);
      tick();
      chk("rt_used_cycles", stall_cycles, 2);

      // branch after load: two stall cycles, 01 then 10
      idle();
      ID_EX_memRead = 1'b1; ID_EX_Rt = 5'd9; IF_ID_Rs = 5'd9; IF_ID_branch = 1'b1;
      branch_taken = 1'b1;
      #1 chk("brld_c1_ctl", ctl(), 5'b00110);
      tick();
      chk("brld_c1_reason", stall_reason, 2'b01);
      ID_EX_memRead = 1'b0; ID_EX_Rt = 5'bx; EX_MEM_memRead = 1'b1; EX_MEM_Rd = 5'd9;
      #1 chk("brld_c2_ctl", ctl(), 5'b00110);
      tick();
      chk("brld_c2_reason", stall_reason, 2'b10);
      chk("brld_cycles", stall_cycles, 4);
      EX_MEM_memRead = 1'b0; ID_EX_Rt = 5'd3;
      #1 chk("brld_c3_release", ctl(), 5'b11101);
      tick();
      chk("brld_c3_reason", stall_reason, 2'b00);
      chk("taken_flush_count", flush_count, 1);
      chk("brld_c3_cycles", stall_cycles, 4);

      // EX_MEM inputs ignored for non-branches
      idle();
      EX_MEM_memRead = 1'bx; EX_MEM_Rd = 5'bx;
      #1 chk("xsafe_ctl", ctl(), 5'b11100);
      tick();

      // taken branch under load-use stall: no flush
      idle();
      ID_EX_memRead = 1'b1; ID_EX_Rt = 5'd8; IF_ID_Rs = 5'd8; IF_ID_branch = 1'b1;
      branch_taken = 1'b1;
      #1 chk("taken_lu_ctl", ctl(), 5'b00110);
      tick();
      chk("taken_lu_flush_count", flush_count, 1);
      chk("taken_lu_cycles", stall_cycles, 5);

      // mem hold beats load-use
      mem_busy = 1'b1;
      #1 chk("hold_ctl", ctl(), 5'b00000);
      tick();
      chk("hold_reason", stall_reason, 2'b11);
      chk("hold_cycles", stall_cycles, 6);
      for (int i = 0; i < 19; i++) tick();
      chk("sat_cycles", stall_cycles, 15);
      chk("sat_reason", stall_reason, 2'b11);
      chk("sat_flush_count", flush_count, 1);

      // async reset mid-hold
      rst_n = 1'b0;
      #1;
      chk("rst_mid_reason", stall_reason, 2'b00);
      chk("rst_mid_cycles", stall_cycles, 0);
      chk("rst_mid_flush", flush_count, 0);
      chk("rst_mid_comb", ctl(), 5'b00000);
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_reason", stall_reason, 2'b00);
      chk("post_rst_cycles", stall_cycles, 0);
      chk("post_rst_ctl", ctl(), 5'b11100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
